b01_stream_driver: RTL

Initiator/checker for the two-line serial comparator FSM interface (line1, line2 in; outp, overflw out).
- Accepts a pair of WIDTH-bit words over a valid/ready handshake.
- Pulses the comparator's reset, then serializes both words LSB-first onto line1/line2, one bit per clock.
- Captures the comparator's per-bit outp/overflw responses into parallel result words, returned over a second valid/ready handshake.
- Sits beside the comparator FSM as its stimulus source and response collector.

---
 rtl/b01_stream_driver.sv | 84 ++++++++
 1 files changed

// File: rtl/b01_stream_driver.sv
// b01_stream_driver: serialises a word pair onto line1/line2 for the b01 comparator and collects its per-bit responses
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_word1/in_word2 input pair handshake;
// line1/line2/fsm_reset drive the comparator; outp_in/overflw_in are its responses;
// res_valid/res_ready/res_outp/res_ovf/res_ovf_any return the captured frame; busy is high outside IDLE.
module b01_stream_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word1,
  input  logic [WIDTH-1:0] in_word2,
  output logic             line1,
  output logic             line2,
  output logic             fsm_reset,
  input  logic             outp_in,
  input  logic             overflw_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_outp,
  output logic [WIDTH-1:0] res_ovf,
  output logic             res_ovf_any,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] index;
  logic [WIDTH-1:0] word1, word2;
  logic sample;
  assign in_ready = (state == IDLE) & ~reset;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  assign res_ovf_any = |res_ovf;
  // the comparator answers one edge late, so the SHIFT index-0 cycle carries no response and DRAIN carries the last one
  assign sample = (state == SHIFT && index != '0) || state == DRAIN;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (in_valid && in_ready) ? CLR : IDLE;
      CLR:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (index == IW'(WIDTH - 1)) ? DRAIN : SHIFT;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = res_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      word1     <= '0;
      word2     <= '0;
      line1     <= 1'b0;
      line2     <= 1'b0;
      fsm_reset <= 1'b1;
      res_outp  <= '0;
      res_ovf   <= '0;
    end else begin
      state     <= state_nxt;
      fsm_reset <= state_nxt == CLR;
      // the latched words shift right so bit 0 is always the next bit to drive
      line1     <= (state_nxt == SHIFT) & word1[0];
      line2     <= (state_nxt == SHIFT) & word2[0];
      if (state == IDLE && state_nxt == CLR) begin
        word1 <= in_word1;
        word2 <= in_word2;
      end else if (state_nxt == SHIFT) begin
        word1 <= word1 >> 1;
        word2 <= word2 >> 1;
      end
      index <= (state == SHIFT) ? index + IW'(1) : '0;
      // responses enter at the MSB; after WIDTH samples the first one sits at bit 0
      if (state == CLR) begin
        res_outp <= '0;
        res_ovf  <= '0;
      end else if (sample) begin
        res_outp <= {outp_in, res_outp[WIDTH-1:1]};
        res_ovf  <= {overflw_in, res_ovf[WIDTH-1:1]};
      end
    end
  end
endmodule
